// File: rtl/command_dispatch_arbiter_pkg.sv
// Shared types for the command dispatch arbiter: command packet, FIFO depth, FSM states.
package command_dispatch_arbiter_pkg;

  localparam int unsigned CMD_OP_W      = 4;
  localparam int unsigned CMD_ADDR_W    = 12;
  localparam int unsigned CMD_DATA_W    = 16;
  localparam int unsigned com_fifo_size = 16;

  typedef struct packed {
    logic [CMD_OP_W-1:0]   opcode;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } com_packet;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/command_dispatch_arbiter_if.sv
// Requester / command-FIFO write-port bundle for the dispatch arbiter.
// CMD_ARB_URGENT_EN adds the per-requester urgent vector.
interface command_dispatch_arbiter_if
  import command_dispatch_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0] req;
  com_packet [NUM_REQ-1:0] req_pkt;
  logic [NUM_REQ-1:0] grant;
  logic               fifo_winc;
  com_packet          fifo_wdata;
  logic               fifo_wfull;
`ifdef CMD_ARB_URGENT_EN
  logic [NUM_REQ-1:0] urgent;
`endif

`ifdef CMD_ARB_URGENT_EN
  modport master (output req, req_pkt, fifo_wfull, urgent,
                  input  grant, fifo_winc, fifo_wdata);
  modport slave  (input  req, req_pkt, fifo_wfull, urgent,
                  output grant, fifo_winc, fifo_wdata);
`else
  modport master (output req, req_pkt, fifo_wfull,
                  input  grant, fifo_winc, fifo_wdata);
  modport slave  (input  req, req_pkt, fifo_wfull,
                  output grant, fifo_winc, fifo_wdata);
`endif

endinterface

// File: rtl/command_dispatch_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping, as a one-hot grant.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c
);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    grant_c = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant_c[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/command_dispatch_arbiter.sv
// Shares the command FIFO write port among NUM_REQ requesters and sequences MAX_ITER replay
// iterations per run. CMD_ARB_URGENT_EN enables urgent-first arbitration.
module command_dispatch_arbiter
  import command_dispatch_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = 4,
  parameter  int unsigned MAX_ITER = 8,
  localparam int unsigned PTR_W    = $clog2(NUM_REQ),
  localparam int unsigned CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic                      wclk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      iter_end,
  command_dispatch_arbiter_if.slave bus,
  output logic                      replay_iter_flag,
  output logic [CNT_W-1:0]          iter_count,
  output logic                      busy,
  output logic                      all_done
);

  arb_state_e         state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]   iter_count_nxt;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] rr_grant;
  logic [NUM_REQ-1:0] gnt;
  logic               grant_en;

  // Urgent requesters form the candidate set whenever any of them is requesting.
`ifdef CMD_ARB_URGENT_EN
  assign arb_req = (|(bus.req & bus.urgent)) ? (bus.req & bus.urgent) : bus.req;
`else
  assign arb_req = bus.req;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req     (arb_req),
    .ptr     (rr_ptr),
    .grant_c (rr_grant)
  );

  always_ff @(posedge wclk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      iter_count <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      iter_count <= iter_count_nxt;
    end
  end

  // Next state and iteration count.
  always_comb begin
    state_nxt      = state;
    iter_count_nxt = iter_count;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt      = ST_RUN;
          iter_count_nxt = '0;
        end
      end
      ST_RUN: begin
        if (iter_end) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        iter_count_nxt = iter_count + CNT_W'(1);
        if ((32'(iter_count) + 32'd1) < MAX_ITER) state_nxt = ST_RUN;
        else                                      state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: zero-latency grant path plus state-decoded status strobes.
  always_comb begin
    grant_en         = 1'b0;
    gnt              = '0;
    rr_ptr_nxt       = rr_ptr;
    bus.fifo_wdata   = '0;
    replay_iter_flag = 1'b0;
    all_done         = 1'b0;
    busy             = (state != ST_IDLE);
    case (state)
      ST_RUN:   grant_en = !bus.fifo_wfull && !iter_end;
      ST_FLUSH: replay_iter_flag = 1'b1;
      ST_DONE:  all_done = 1'b1;
      default:  grant_en = 1'b0;
    endcase
    if (grant_en) gnt = rr_grant;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        bus.fifo_wdata = bus.req_pkt[k];
        rr_ptr_nxt     = PTR_W'((k + 1) % NUM_REQ);
      end
    end
    bus.grant     = gnt;
    bus.fifo_winc = |gnt;
  end

endmodule

// File: tb/tb_command_dispatch_arbiter.sv
// Bench for command_dispatch_arbiter: directed scenarios plus randomized traffic against a
// behavioural model. The urgent scenario is built only with CMD_ARB_URGENT_EN.
module tb_command_dispatch_arbiter;
  import command_dispatch_arbiter_pkg::*;

  localparam int unsigned N      = 4;
  localparam int unsigned MAX_IT = 2;
  localparam int unsigned CNT_W  = $clog2(MAX_IT + 1);
  localparam int unsigned P_IDLE = 0, P_RUN = 1, P_FLUSH = 2, P_DONE = 3;

  logic             wclk = 1'b0;
  logic             reset;
  logic             start;
  logic             iter_end;
  logic             replay_iter_flag;
  logic [CNT_W-1:0] iter_count;
  logic             busy;
  logic             all_done;
  logic [N-1:0]     urg;
  logic [N-1:0]     pend;
  com_packet        pkt [N];

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int unsigned m_phase, m_ptr, m_iter;

  command_dispatch_arbiter_if #(.NUM_REQ(N)) bus ();

`ifdef CMD_ARB_URGENT_EN
  assign bus.urgent = urg;
`endif

  command_dispatch_arbiter #(.NUM_REQ(N), .MAX_ITER(MAX_IT)) dut (
    .wclk             (wclk),
    .reset            (reset),
    .start            (start),
    .iter_end         (iter_end),
    .bus              (bus),
    .replay_iter_flag (replay_iter_flag),
    .iter_count       (iter_count),
    .busy             (busy),
    .all_done         (all_done)
  );

  always #5 wclk = ~wclk;

  // Pick the requester closest (cyclically) at or after ptr, urgent ones first.
  function automatic logic [N-1:0] model_pick(input logic [N-1:0] r, input logic [N-1:0] u,
                                              input int unsigned ptr);
    logic [N-1:0] cand;
    int           best;
    int unsigned  bestd;
    cand  = ((r & u) != '0) ? (r & u) : r;
    best  = -1;
    bestd = N;
    for (int unsigned k = 0; k < N; k++) begin
      if (cand[k] && ((k + N - ptr) % N) < bestd) begin
        bestd = (k + N - ptr) % N;
        best  = int'(k);
      end
    end
    model_pick = '0;
    if (best >= 0) model_pick[best] = 1'b1;
  endfunction

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_req(input logic [N-1:0] r);
    bus.req = r;
    for (int k = 0; k < N; k++) bus.req_pkt[k] = pkt[k];
  endtask

  task automatic test_reset();
    start = 1'b0; iter_end = 1'b0; bus.fifo_wfull = 1'b0; urg = '0;
    for (int k = 0; k < N; k++) pkt[k] = com_packet'($urandom);
    set_req('1);
    reset = 1'b0;
    #12;
    checks++;
    if ({bus.grant, bus.fifo_winc, busy, all_done, replay_iter_flag, iter_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0",
               {bus.grant, bus.fifo_winc, busy, all_done, replay_iter_flag, iter_count});
    end
    checks++;
    if (bus.fifo_wdata !== '0) begin
      errors++; $display("FAIL reset_wdata got=%h exp=0", bus.fifo_wdata);
    end
    set_req('0);
    @(negedge wclk) reset = 1'b1;
    step();
    @(negedge wclk);
    checks++;
    if (bus.grant !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset grant=%b busy=%b exp=0/0", bus.grant, busy);
    end
    step();
  endtask

  task automatic test_round_robin();
    int winc_cnt;
    logic [N-1:0] exp_g;
    winc_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < N; k++) pkt[k] = com_packet'($urandom);
    set_req(4'b1111);
    for (int i = 0; i < 8; i++) begin
      @(negedge wclk);
      exp_g = N'(1) << (i % 4);
      checks++;
      if (bus.grant !== exp_g) begin
        errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, bus.grant, exp_g);
      end
      checks++;
      if (bus.fifo_wdata !== pkt[i % 4]) begin
        errors++; $display("FAIL rr_wdata[%0d] got=%h exp=%h", i, bus.fifo_wdata, pkt[i % 4]);
      end
      if (bus.fifo_winc === 1'b1) winc_cnt++;
      step();
    end
    set_req('0);
    checks++;
    if (winc_cnt != 8) begin
      errors++; $display("FAIL rr_winc_count got=%0d exp=8", winc_cnt);
    end
  endtask

  task automatic test_wfull();
    set_req(4'b0100);
    bus.fifo_wfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge wclk);
      checks++;
      if (bus.grant !== '0 || bus.fifo_winc !== 1'b0 || bus.fifo_wdata !== '0) begin
        errors++;
        $display("FAIL wfull_hold[%0d] grant=%b winc=%b exp=0/0", i, bus.grant, bus.fifo_winc);
      end
      step();
    end
    bus.fifo_wfull = 1'b0;
    @(negedge wclk);
    checks++;
    if (bus.grant !== 4'b0100) begin
      errors++; $display("FAIL wfull_release got=%b exp=0100", bus.grant);
    end
    step();
    set_req('0);
  endtask

  task automatic test_iter_end_collision();
    set_req(4'b0001);
    iter_end = 1'b1;
    @(negedge wclk);
    checks++;
    if (bus.grant !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL collide_no_grant grant=%b busy=%b exp=0000/1", bus.grant, busy);
    end
    step();
    iter_end = 1'b0;
    @(negedge wclk);
    checks++;
    if (replay_iter_flag !== 1'b1 || bus.grant !== '0) begin
      errors++;
      $display("FAIL collide_flush replay=%b grant=%b exp=1/0000", replay_iter_flag, bus.grant);
    end
    step();
    @(negedge wclk);
    checks++;
    if (bus.grant !== 4'b0001 || replay_iter_flag !== 1'b0 || iter_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL collide_regrant grant=%b replay=%b cnt=%0d exp=0001/0/1",
               bus.grant, replay_iter_flag, iter_count);
    end
    step();
    set_req('0);
    // Second iteration end closes this run.
    iter_end = 1'b1;
    step();
    iter_end = 1'b0;
    step();
    @(negedge wclk);
    checks++;
    if (all_done !== 1'b1 || iter_count !== CNT_W'(2)) begin
      errors++; $display("FAIL collide_done all_done=%b cnt=%0d exp=1/2", all_done, iter_count);
    end
    step();
  endtask

  task automatic test_iterations();
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge wclk);
    checks++;
    if (iter_count !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL iter_clear cnt=%0d busy=%b exp=0/1", iter_count, busy);
    end
    for (int it = 1; it <= 2; it++) begin
      iter_end = 1'b1;
      step();
      iter_end = 1'b0;
      @(negedge wclk);
      checks++;
      if (replay_iter_flag !== 1'b1 || iter_count !== CNT_W'(it - 1)) begin
        errors++;
        $display("FAIL iter_flush[%0d] replay=%b cnt=%0d exp=1/%0d",
                 it, replay_iter_flag, iter_count, it - 1);
      end
      step();
      @(negedge wclk);
      checks++;
      if (replay_iter_flag !== 1'b0 || iter_count !== CNT_W'(it) || all_done !== (it == 2)) begin
        errors++;
        $display("FAIL iter_after[%0d] replay=%b cnt=%0d done=%b exp=0/%0d/%0d",
                 it, replay_iter_flag, iter_count, all_done, it, (it == 2));
      end
    end
    step();
    @(negedge wclk);
    checks++;
    if (busy !== 1'b0 || all_done !== 1'b0) begin
      errors++; $display("FAIL iter_idle busy=%b done=%b exp=0/0", busy, all_done);
    end
  endtask

  task automatic test_reset_mid_run();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    set_req(4'b1111);
    @(negedge wclk);
    checks++;
    if (bus.fifo_winc !== 1'b1) begin
      errors++; $display("FAIL midrun_active winc=%b exp=1", bus.fifo_winc);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.grant, bus.fifo_winc, busy, iter_count} !== '0 || bus.fifo_wdata !== '0) begin
      errors++;
      $display("FAIL midrun_async grant=%b winc=%b busy=%b cnt=%0d exp=0",
               bus.grant, bus.fifo_winc, busy, iter_count);
    end
    @(negedge wclk) reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge wclk);
      checks++;
      if (bus.grant !== '0 || busy !== 1'b0) begin
        errors++; $display("FAIL midrun_nostart[%0d] grant=%b busy=%b exp=0/0", i, bus.grant, busy);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge wclk);
    checks++;
    if (bus.grant !== 4'b0001) begin
      errors++; $display("FAIL midrun_restart got=%b exp=0001", bus.grant);
    end
    // Reset landing inside a FLUSH cycle drops the replay.
    iter_end = 1'b1;
    step();
    iter_end = 1'b0;
    #2;
    checks++;
    if (replay_iter_flag !== 1'b1) begin
      errors++; $display("FAIL flush_reset_pre replay=%b exp=1", replay_iter_flag);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (replay_iter_flag !== 1'b0 || busy !== 1'b0 || iter_count !== '0) begin
      errors++;
      $display("FAIL flush_reset_async replay=%b busy=%b cnt=%0d exp=0/0/0",
               replay_iter_flag, busy, iter_count);
    end
    @(negedge wclk) reset = 1'b1;
    step();
    @(negedge wclk);
    checks++;
    if (busy !== 1'b0 || replay_iter_flag !== 1'b0 || iter_count !== '0) begin
      errors++;
      $display("FAIL flush_dropped busy=%b replay=%b cnt=%0d exp=0/0/0",
               busy, replay_iter_flag, iter_count);
    end
    set_req('0);
    step();
  endtask

`ifdef CMD_ARB_URGENT_EN
  task automatic test_urgent();
    logic [N-1:0] exp_seq [4];
    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0010; exp_seq[3] = 4'b0001;
    start = 1'b1;
    step();
    start = 1'b0;
    urg = 4'b1000;
    set_req(4'b1011);
    for (int i = 0; i < 4; i++) begin
      @(negedge wclk);
      checks++;
      if (bus.grant !== exp_seq[i]) begin
        errors++; $display("FAIL urgent_seq[%0d] got=%b exp=%b", i, bus.grant, exp_seq[i]);
      end
      step();
      if (i == 0) set_req(4'b0011);
    end
    urg = '0;
    set_req('0);
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] exp_g;
    com_packet    exp_d;
    reset = 1'b0;
    #1 reset = 1'b1;
    m_phase = P_IDLE; m_ptr = 0; m_iter = 0;
    pend = '0;
    step();
    for (int c = 0; c < 400; c++) begin
      start          = ($urandom_range(7) == 0);
      iter_end       = ($urandom_range(5) == 0);
      bus.fifo_wfull = ($urandom_range(3) == 0);
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(1) == 1) begin
          pend[k] = 1'b1;
          pkt[k]  = com_packet'($urandom);
        end
      end
`ifdef CMD_ARB_URGENT_EN
      urg = N'($urandom);
`endif
      set_req(pend);
      @(negedge wclk);
      exp_g = '0;
      if (m_phase == P_RUN && !bus.fifo_wfull && !iter_end) exp_g = model_pick(pend, urg, m_ptr);
      exp_d = '0;
      for (int k = 0; k < N; k++) if (exp_g[k]) exp_d = pkt[k];
      checks++;
      if (bus.grant !== exp_g || bus.fifo_winc !== (exp_g != '0)) begin
        errors++;
        $display("FAIL rand_grant[%0d] got=%b/%b exp=%b", c, bus.grant, bus.fifo_winc, exp_g);
      end
      checks++;
      if (bus.fifo_wdata !== exp_d) begin
        errors++; $display("FAIL rand_wdata[%0d] got=%h exp=%h", c, bus.fifo_wdata, exp_d);
      end
      checks++;
      if ({busy, replay_iter_flag, all_done} !==
          {m_phase != P_IDLE, m_phase == P_FLUSH, m_phase == P_DONE}) begin
        errors++;
        $display("FAIL rand_status[%0d] got=%b exp=%b", c, {busy, replay_iter_flag, all_done},
                 {m_phase != P_IDLE, m_phase == P_FLUSH, m_phase == P_DONE});
      end
      checks++;
      if (iter_count !== CNT_W'(m_iter)) begin
        errors++; $display("FAIL rand_iter_count[%0d] got=%0d exp=%0d", c, iter_count, m_iter);
      end
      @(posedge wclk);
      for (int unsigned k = 0; k < N; k++) if (exp_g[k]) m_ptr = (k + 1) % N;
      case (m_phase)
        P_IDLE:  if (start) begin m_phase = P_RUN; m_iter = 0; end
        P_RUN:   if (iter_end) m_phase = P_FLUSH;
        P_FLUSH: begin m_iter++; m_phase = (m_iter < MAX_IT) ? P_RUN : P_DONE; end
        default: m_phase = P_IDLE;
      endcase
      pend = pend & ~exp_g;
      #1;
    end
    start = 1'b0; iter_end = 1'b0; bus.fifo_wfull = 1'b0; urg = '0;
    set_req('0);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wfull();
    test_iter_end_collision();
    test_iterations();
    test_reset_mid_run();
`ifdef CMD_ARB_URGENT_EN
    test_urgent();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/command_dispatch_arbiter.md
COMMAND_DISPATCH_ARBITER -- requirements
Module: command_dispatch_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing the command FIFO write port; legal range 2..8.
REQ-002 Parameter MAX_ITER, 8, number of replay iterations per run; legal range 1..255.
REQ-003 wclk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse that begins a run.
REQ-006 req  input  NUM_REQ  per-requester request; held high with its packet until granted.
REQ-007 req_pkt  input  NUM_REQ x com_packet  per-requester command packet.
REQ-008 grant  output  NUM_REQ  one-hot acceptance strobe; the packet is consumed in the same cycle.
REQ-009 fifo_winc  output  1  write strobe to the command FIFO.
REQ-010 fifo_wdata  output  com_packet  packet of the granted requester.
REQ-011 fifo_wfull  input  1  full flag from the command FIFO.
REQ-012 iter_end  input  1  single-cycle pulse from the consumer marking the end of an iteration.
REQ-013 replay_iter_flag  output  1  single-cycle pulse that rewinds both FIFO pointers.
REQ-014 iter_count  output  $clog2(MAX_ITER+1)  number of completed iterations in the current run.
REQ-015 busy  output  1  high in every state other than IDLE.
REQ-016 all_done  output  1  single-cycle pulse when the run completes.

Function
REQ-017 The FSM SHALL have four states: IDLE, RUN, FLUSH and DONE.
REQ-018 Transitions SHALL be: IDLE->RUN on start; RUN->FLUSH on iter_end; FLUSH->RUN when the incremented iter_count < MAX_ITER, else FLUSH->DONE; DONE->IDLE unconditionally after one cycle.
REQ-019 Grants SHALL be issued only in RUN, only when fifo_wfull=0, and only when iter_end=0 in that cycle.
REQ-020 At most one grant bit SHALL be high per cycle; fifo_winc SHALL equal OR(grant); fifo_wdata SHALL equal req_pkt of the granted index, and SHALL be 0 when no grant is issued.
REQ-021 Grant, fifo_winc and fifo_wdata SHALL be combinational from the registered state, the round-robin pointer and the current inputs, giving zero-cycle acceptance latency.
REQ-022 Arbitration SHALL be round-robin: search starts at rr_ptr; after a grant to index k, rr_ptr SHALL become (k+1) mod NUM_REQ; rr_ptr SHALL hold when there is no grant.
REQ-023 replay_iter_flag SHALL be high exactly in the FLUSH cycle, and iter_count SHALL increment on exit from FLUSH.
REQ-024 all_done SHALL be high exactly in the DONE cycle; iter_count SHALL clear to 0 on IDLE->RUN.
REQ-025 start SHALL be ignored outside IDLE; iter_end SHALL be ignored outside RUN.
REQ-026 A requester held off by fifo_wfull SHALL keep its turn: rr_ptr does not move while full.

Reset
REQ-027 Asserting reset SHALL immediately force state=IDLE, rr_ptr=0 and iter_count=0, and all outputs to 0, including during RUN or FLUSH.
REQ-028 A FLUSH pulse in progress at reset SHALL be dropped, not completed.

Configuration
REQ-029 Macro CMD_ARB_URGENT_EN SHALL add input urgent (NUM_REQ wide).
REQ-030 With CMD_ARB_URGENT_EN defined, any requester with req&urgent set SHALL win ahead of non-urgent requesters, with round-robin applied within the urgent set and the same rr_ptr update.
REQ-031 Without CMD_ARB_URGENT_EN, the urgent port SHALL NOT exist and arbitration SHALL be pure round-robin.

Structure
REQ-032 com_packet, com_fifo_size and the FSM state enum SHALL live in the shared project package.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector and pointer; output: one-hot grant).

Verification
REQ-034 Scenario: reset, start, req=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3 and 8 fifo_winc pulses.
REQ-035 Scenario: fifo_wfull=1 for 3 cycles with req=4'b0100 -> no grant during those cycles; grant[2] in the first cycle after wfull falls.
REQ-036 Scenario: MAX_ITER=2, with iter_end pulsed twice -> each pulse produces one replay_iter_flag cycle; iter_count goes 1 then 2; all_done follows the second FLUSH; busy=0 afterwards.
REQ-037 Scenario: iter_end and req=4'b0001 in the same RUN cycle -> no grant that cycle; FLUSH next cycle; grant[0] in the first RUN cycle after FLUSH.
REQ-038 Scenario: reset asserted mid-RUN with requests pending -> outputs 0 asynchronously; start is required before any new grant.
REQ-039 Scenario: CMD_ARB_URGENT_EN defined, req=4'b1011, urgent=4'b1000 -> grant[3] first, then round-robin among 0 and 1.
